shell_controller: RTL
=====================

# shell_controller

Per-player shell generator and mover that produces the shell position/valid bundle consumed by the playfield shell renderer. It owns five shell slots. It spawns a shell in front of the tank on a fire request, advances all in-flight shells one grid cell per movement tick, and retires shells that leave the map or are reported hit. Two instances exist in the game core, one per player, feeding the `shell0_*` and `shell1_*` display inputs.

## Interface
Parameters:
- `MAP_W`, default 40: playfield width in cells; legal x is 0..MAP_W-1, with MAP_W ≤ 64.
- `MAP_H`, default 30: playfield height in cells; legal y is 0..MAP_H-1, with MAP_H ≤ 64.
- `COOLDOWN`, default 4: number of `i_tick` pulses after a successful fire during which further fires are refused.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_tick`  in  1  one-cycle movement strobe.
- `i_fire`  in  1  one-cycle fire request.
- `i_tank_x`, `i_tank_y`  in  6 each  tank cell.
- `i_tank_dir`  in  2  tank facing; 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1).
- `i_hit`  in  5  per-slot kill from the collision detector; bit i retires slot i.
- `o_shell_0_x` … `o_shell_4_x`, `o_shell_0_y` … `o_shell_4_y`  out  6 each  slot positions.
- `o_shell_valid`  out  5  slot free flag. 1 = free/not drawn, 0 = in flight/drawn. This matches the renderer, which draws a slot only when its bit is low.
- `o_fire_ack`  out  1  one-cycle pulse when a fire was accepted.
- `o_fire_nack`  out  1  one-cycle pulse when a fire was refused.

## Operation
- Per-slot state: x, y, dir, and free. All outputs are registered.
- Reset values: all x/y = 0, dir = 0, `o_shell_valid` = 5'b11111, ack/nack = 0, cooldown = 0, bounce flags = 0.
- Fire acceptance requires all of the following:
  - `i_fire` = 1.
  - cooldown = 0.
  - at least one free slot in the current (registered) mask.
  - spawn cell inside the map.
- Spawn cell is the tank cell plus one step in `i_tank_dir`. Arithmetic is 7-bit signed. The spawn is out of map if the result is < 0 or ≥ MAP_W/MAP_H.
- On acceptance:
  - Allocate the lowest-index free slot.
  - Load spawn x/y and dir into it; clear its free bit.
  - Load cooldown with COOLDOWN; pulse `o_fire_ack`.
- On refusal: pulse `o_fire_nack`; no state changes.
- Cooldown decrements on each `i_tick` while nonzero and saturates at 0.
- Movement: on `i_tick`, each occupied slot computes its next cell (same 7-bit rule).
  - In-map: the slot moves.
  - Out-of-map: the slot is retired (free = 1); its x/y hold their last value.
- Priority per slot within one cycle: reset > hit > move.
  - A slot with `i_hit` set retires and does not move.
  - `i_hit` on a free slot is ignored.
- A slot allocated in cycle N is not moved by an `i_tick` in cycle N. Its first move is on the next tick.
- A slot retiring in cycle N is not reusable until N+1, because allocation uses the registered free mask.
- Freed slots keep stale x/y. Consumers must gate on `o_shell_valid`.

## Timing
- Fire in cycle N: slot occupied and ack/nack visible at N+1; ack/nack is low at N+2.
- Tick in cycle N: positions and retirements visible at N+1.
- Hit in cycle N: `o_shell_valid` bit set at N+1.
- Reset asserted mid-flight: all slots free on the next edge, and any pending fire is dropped with no ack or nack.
- Back-to-back fires with COOLDOWN = 0 are accepted every cycle until all 5 slots are full.

## Configuration
- Macro: `SHELL_BOUNCE_EN`.
- Defined: each slot has a bounce flag.
  - First out-of-map step: direction is reversed (dir ^ 2'b10), position is unchanged, and the bounce flag is set.
  - Second out-of-map step: the slot retires.
  - The flag clears on allocation and on reset.
- Undefined: the first out-of-map step retires the slot; no bounce flags are synthesised.

## Structure
- Shared package `game_pkg`:
  - `dir_t` enum (UP=0, RIGHT=1, DOWN=2, LEFT=3).
  - `SHELL_NUM` = 5.
  - `COORD_W` = 6.
  - `step_t` helper function returning the next cell as signed 7-bit dx/dy.
- Sub-module `shell_slot`, instantiated 5 times:
  - Holds one slot's registers.
  - Takes load/move/kill strobes plus spawn data.
  - Outputs x, y, free.
- The top level holds the allocator (lowest-free priority encoder), the cooldown counter, and ack/nack generation.

## Test plan
- Reset, then fire with tank (10,10) dir 1 → at N+1: slot 0 = (11,10), `o_shell_valid` = 5'b11110, ack = 1.
- Three ticks after that fire → slot 0 = (14,10); cooldown reaches 0 after the 4th tick.
- Tank (39,5) dir 1, MAP_W 40, fire → nack, `o_shell_valid` unchanged. Shell at (0,7) dir 3, then tick → retired (bit = 1).
- COOLDOWN = 0, fire on 6 consecutive cycles → slots 0–4 allocated in order with 5 acks, 6th fire nacks. `i_hit` = 5'b00100 together with a tick → slot 2 freed and not moved; the others move.
- With `SHELL_BOUNCE_EN`, shell at (0,7) dir 3, tick → (0,7) dir 1; next tick → (1,7); further ticks toward x = 39 until the second out-of-map step → retired.
- Reset asserted concurrently with `i_fire` while 3 shells are in flight → all free at the next edge, ack = 0, nack = 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared shell types, sizes and the one-step grid move helper.
package game_pkg;

    localparam int SHELL_NUM = 5;
    localparam int COORD_W = 6;

    typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;

    typedef struct packed {
        logic signed [COORD_W:0] x;
        logic signed [COORD_W:0] y;
    } cell_t;

    // Next cell in 7-bit signed arithmetic so that stepping off either edge stays detectable.
    function automatic cell_t step_t(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input dir_t dir);
        cell_t c;
        c.x = $signed({1'b0, x}) + ((dir == RIGHT) ? 7'sd1 : (dir == LEFT) ? -7'sd1 : 7'sd0);
        c.y = $signed({1'b0, y}) + ((dir == DOWN) ? 7'sd1 : (dir == UP) ? -7'sd1 : 7'sd0);
        return c;
    endfunction

    function automatic logic in_map(input cell_t c, input logic [COORD_W:0] w, input logic [COORD_W:0] h);
        return !c.x[COORD_W] && !c.y[COORD_W] && ({1'b0, c.x[COORD_W-1:0]} < w) && ({1'b0, c.y[COORD_W-1:0]} < h);
    endfunction

endpackage

// File: rtl/shell_slot.sv
// shell_slot: one shell's position/direction/free registers with load > kill > move priority.
// SHELL_BOUNCE_EN adds a per-slot bounce flag that reverses the shell once at the map edge.
module shell_slot
    import game_pkg::*;
#(
    parameter int MAP_W = 40,
    parameter int MAP_H = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               move_i,
    input  logic               kill_i,
    input  logic [COORD_W-1:0] spawn_x_i,
    input  logic [COORD_W-1:0] spawn_y_i,
    input  logic [1:0]         spawn_dir_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               free_o
);

    localparam logic [COORD_W:0] W7 = 7'(MAP_W);
    localparam logic [COORD_W:0] H7 = 7'(MAP_H);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    dir_t               dir_q, dir_d;
    logic               free_q, free_d;
    cell_t              nxt;
    logic               nxt_ok;
`ifdef SHELL_BOUNCE_EN
    logic               bnc_q, bnc_d;
`endif

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        dir_d  = dir_q;
        free_d = free_q;
`ifdef SHELL_BOUNCE_EN
        bnc_d  = bnc_q;
`endif
        nxt    = step_t(x_q, y_q, dir_q);
        nxt_ok = in_map(nxt, W7, H7);
        if (load_i) begin
            x_d    = spawn_x_i;
            y_d    = spawn_y_i;
            dir_d  = dir_t'(spawn_dir_i);
            free_d = 1'b0;
`ifdef SHELL_BOUNCE_EN
            bnc_d  = 1'b0;
`endif
        end else if (!free_q && kill_i) begin
            free_d = 1'b1;
        end else if (!free_q && move_i) begin
            if (nxt_ok) begin
                x_d = nxt.x[COORD_W-1:0];
                y_d = nxt.y[COORD_W-1:0];
            end else begin
`ifdef SHELL_BOUNCE_EN
                // First edge hit turns the shell around in place; the second one retires it.
                dir_d  = bnc_q ? dir_q : dir_t'(dir_q ^ 2'b10);
                free_d = bnc_q;
                bnc_d  = 1'b1;
`else
                free_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            dir_q  <= UP;
            free_q <= 1'b1;
`ifdef SHELL_BOUNCE_EN
            bnc_q  <= 1'b0;
`endif
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            dir_q  <= dir_d;
            free_q <= free_d;
`ifdef SHELL_BOUNCE_EN
            bnc_q  <= bnc_d;
`endif
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign free_o = free_q;

endmodule

// File: rtl/shell_controller.sv
// shell_controller: five-slot shell spawner/mover with fire cooldown and ack/nack pulses.
// SHELL_BOUNCE_EN (see shell_slot) makes shells bounce once off the map edge before retiring.
module shell_controller
    import game_pkg::*;
#(
    parameter int MAP_W    = 40,
    parameter int MAP_H    = 30,
    parameter int COOLDOWN = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_fire,
    input  logic [COORD_W-1:0] i_tank_x,
    input  logic [COORD_W-1:0] i_tank_y,
    input  logic [1:0]         i_tank_dir,
    input  logic [SHELL_NUM-1:0] i_hit,
    output logic [COORD_W-1:0] o_shell_0_x,
    output logic [COORD_W-1:0] o_shell_1_x,
    output logic [COORD_W-1:0] o_shell_2_x,
    output logic [COORD_W-1:0] o_shell_3_x,
    output logic [COORD_W-1:0] o_shell_4_x,
    output logic [COORD_W-1:0] o_shell_0_y,
    output logic [COORD_W-1:0] o_shell_1_y,
    output logic [COORD_W-1:0] o_shell_2_y,
    output logic [COORD_W-1:0] o_shell_3_y,
    output logic [COORD_W-1:0] o_shell_4_y,
    output logic [SHELL_NUM-1:0] o_shell_valid,
    output logic               o_fire_ack,
    output logic               o_fire_nack
);

    localparam int CD_W = $clog2(COOLDOWN + 2);
    localparam logic [COORD_W:0] W7 = 7'(MAP_W);
    localparam logic [COORD_W:0] H7 = 7'(MAP_H);

    logic [COORD_W-1:0]   sx [SHELL_NUM];
    logic [COORD_W-1:0]   sy [SHELL_NUM];
    logic [SHELL_NUM-1:0] free_w, load_w;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 ack_q, ack_d, nack_q, nack_d;
    cell_t                spawn;
    logic                 accept;

    always_comb begin
        spawn  = step_t(i_tank_x, i_tank_y, dir_t'(i_tank_dir));
        accept = i_fire && (cd_q == '0) && (|free_w) && in_map(spawn, W7, H7);
        // Isolating the lowest set bit of the registered free mask picks the allocation target.
        load_w = accept ? (free_w & (-free_w)) : '0;
        cd_d   = accept ? CD_W'(COOLDOWN) : (i_tick && cd_q != '0) ? cd_q - CD_W'(1) : cd_q;
        ack_d  = accept;
        nack_d = i_fire && !accept;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cd_q   <= '0;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            cd_q   <= cd_d;
            ack_q  <= ack_d;
            nack_q <= nack_d;
        end
    end

    for (genvar i = 0; i < SHELL_NUM; i++) begin : g_slot
        shell_slot #(.MAP_W(MAP_W), .MAP_H(MAP_H)) u_slot (
            .clk         (i_clk),
            .rst         (i_rst),
            .load_i      (load_w[i]),
            .move_i      (i_tick),
            .kill_i      (i_hit[i]),
            .spawn_x_i   (spawn.x[COORD_W-1:0]),
            .spawn_y_i   (spawn.y[COORD_W-1:0]),
            .spawn_dir_i (i_tank_dir),
            .x_o         (sx[i]),
            .y_o         (sy[i]),
            .free_o      (free_w[i])
        );
    end

    assign o_shell_0_x   = sx[0];
    assign o_shell_1_x   = sx[1];
    assign o_shell_2_x   = sx[2];
    assign o_shell_3_x   = sx[3];
    assign o_shell_4_x   = sx[4];
    assign o_shell_0_y   = sy[0];
    assign o_shell_1_y   = sy[1];
    assign o_shell_2_y   = sy[2];
    assign o_shell_3_y   = sy[3];
    assign o_shell_4_y   = sy[4];
    assign o_shell_valid = free_w;
    assign o_fire_ack    = ack_q;
    assign o_fire_nack   = nack_q;

endmodule
